// File: rtl/axil_reg_arbiter.sv
// ---------------------------------------------------------------------------
// axil_reg_arbiter
//
// Two-requester round-robin arbiter in front of a single AXI4-Lite master
// port. One transaction is in flight at a time: the granted requester's
// we/addr/wdata are latched, the AXI-Lite handshakes are run, and a single
// done pulse with rdata/err is returned to that requester.
//
// Optional feature: define ARB_TIMEOUT_EN to enable a watchdog that aborts
// a transaction stuck for TIMEOUT_CYCLES cycles. It then completes with
// err=1 and rdata=32'h0BAD0BAD.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   req[1:0], we[1:0]     : per-requester level request and write select
//   addr[63:0]            : requester i address at [32i+31:32i]
//   wdata[63:0]           : requester i write data at [32i+31:32i]
//   done[1:0]             : one-cycle completion pulse to the served requester
//   rdata[31:0], err      : completion data/status, valid while done != 0
//   m_axi_*               : AXI4-Lite master (AW, W, B, AR, R channels)
// ---------------------------------------------------------------------------
module axil_reg_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  done,
  output logic [31:0] rdata,
  output logic        err,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  input  logic [1:0]  m_axi_bresp,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {IDLE, WR, WRESP, RADDR, RDATA, DONE} state_e;

  state_e      state_q, state_d;
  logic        prio_q, prio_d;       // requester that wins a tie
  logic        gnt_q, gnt_d;         // requester currently being served
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        awvalid_q, awvalid_d;
  logic        wvalid_q, wvalid_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        gnt_sel;

`ifdef ARB_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            busy;
`endif

  // A lone request wins outright; a tie goes to the requester not served last.
  assign gnt_sel = (req == 2'b11) ? prio_q : req[1];

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a signal unassigned (which would infer a latch).
    state_d   = state_q;
    prio_d    = prio_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rdata_d   = rdata_q;
    err_d     = err_q;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = gnt_sel;
          prio_d  = ~gnt_sel;
          addr_d  = gnt_sel ? addr[63:32]  : addr[31:0];
          wdata_d = gnt_sel ? wdata[63:32] : wdata[31:0];
          if (we[gnt_sel]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RADDR;
          end
        end
      end
      WR: begin
        // AW and W complete independently; leave once neither is pending.
        if (awvalid_q && m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi_awready) && (!wvalid_q || m_axi_wready)) begin
          state_d = WRESP;
        end
      end
      WRESP: begin
        if (m_axi_bvalid) begin
          err_d   = |m_axi_bresp;
          rdata_d = 32'h0;
          state_d = DONE;
        end
      end
      RADDR: begin
        if (m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = RDATA;
        end
      end
      RDATA: begin
        if (m_axi_rvalid) begin
          rdata_d = m_axi_rdata;
          err_d   = |m_axi_rresp;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

`ifdef ARB_TIMEOUT_EN
    busy   = (state_q != IDLE) && (state_q != DONE);
    wdog_d = busy ? wdog_q + 1'b1 : '0;
    // The abort overrides whatever handshake the case above may have taken.
    if (busy && (wdog_q == WD_LAST)) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      err_d     = 1'b1;
      rdata_d   = 32'h0BAD0BAD;
      state_d   = DONE;
    end
`endif
  end

  // NOTE: state is updated only with non-blocking assignments so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and covers every flop, so an in-flight
    // transaction is dropped without reaching DONE.
    if (reset) begin
      state_q   <= IDLE;
      prio_q    <= 1'b0;
      gnt_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wdog_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      gnt_q     <= gnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
`ifdef ARB_TIMEOUT_EN
      wdog_q    <= wdog_d;
`endif
    end
  end

  // One address register feeds both channels; only one valid is ever high.
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_bready  = (state_q == WRESP);
  assign m_axi_rready  = (state_q == RDATA);

  assign done  = (state_q == DONE) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
  assign rdata = rdata_q;
  assign err   = err_q;

endmodule

// File: tb/tb_axil_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axil_reg_arbiter
//
// Directed and randomized transactions against axil_reg_arbiter with a
// behavioural AXI-Lite slave driven from the stimulus sequence. Expected
// grant, completion data, error and grant-to-done latency come from a
// reference model of the arbitration and handshake rules.
// ---------------------------------------------------------------------------
module tb_axil_reg_arbiter;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req, we;
  logic [63:0] addr, wdata;
  logic [1:0]  done;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] m_axi_awaddr, m_axi_wdata, m_axi_araddr, m_axi_rdata;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [3:0]  m_axi_wstrb;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic [1:0]  m_axi_bresp, m_axi_rresp;

  int n_vec = 0;
  int n_err = 0;
  int model_prio = 0;

  axil_reg_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .done(done), .rdata(rdata), .err(err),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_bresp(m_axi_bresp),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rresp(m_axi_rresp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic slave_idle();
    m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = 1'b0; m_axi_bresp = 2'b00;
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = 32'h0; m_axi_rresp = 2'b00;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valids"}, {27'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                             m_axi_arvalid, m_axi_rready}, 32'h0);
    check({tag, "_done"},   {30'h0, done}, 32'h0);
    check({tag, "_awaddr"}, m_axi_awaddr, 32'h0);
    check({tag, "_araddr"}, m_axi_araddr, 32'h0);
    check({tag, "_wdata"},  m_axi_wdata, 32'h0);
    check({tag, "_rdata"},  rdata, 32'h0);
    check({tag, "_err"},    {31'h0, err}, 32'h0);
  endtask

  // One transaction, starting on the IDLE cycle in which the request is seen
  // (cycle 0). The slave waits *_dly cycles after the relevant valid (or, for
  // B/R, after entering the response phase) before completing a handshake.
  task automatic run_txn(input string tag, input logic [1:0] r, input logic [1:0] w,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [31:0] d0, input logic [31:0] d1,
                         input int aw_dly, input int w_dly, input int b_dly,
                         input int ar_dly, input int r_dly,
                         input logic [1:0] resp, input logic [31:0] sdata,
                         input bit keep, input bit exp_tmo, output int gnt_seen);
    int g, exp_cyc, aw_wait, w_wait, b_wait, ar_wait, r_wait;
    int aw_beats, w_beats, ar_beats, proto;
    bit is_wr, found, aw_done, w_done, b_done, ar_done, r_done;
    logic [31:0] ea, ed, exp_rd;
    logic exp_err;

    @(negedge clk);
    req = r; we = w; addr = {a1, a0}; wdata = {d1, d0};
    g = (r == 2'b11) ? model_prio : (r[1] ? 1 : 0);
    model_prio = 1 - g;
    is_wr = w[g];
    ea = g ? a1 : a0;
    ed = g ? d1 : d0;
    if (exp_tmo) begin
      exp_rd = 32'h0BAD0BAD; exp_err = 1'b1; exp_cyc = TMO + 1;
    end else if (is_wr) begin
      exp_rd = 32'h0; exp_err = (resp != 2'b00);
      exp_cyc = ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly + 3;
    end else begin
      exp_rd = sdata; exp_err = (resp != 2'b00);
      exp_cyc = ar_dly + r_dly + 3;
    end

    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
    aw_beats = 0; w_beats = 0; ar_beats = 0; proto = 0;
    aw_done = 0; w_done = 0; b_done = 0; ar_done = 0; r_done = 0;
    found = 0; gnt_seen = -1;

    for (int cyc = 1; cyc <= 64 && !found; cyc++) begin
      @(negedge clk);
      if (done != 2'b00) begin
        found = 1;
        gnt_seen = done[1] ? 1 : 0;
        check({tag, "_done"},    {30'h0, done}, (g == 1) ? 32'h2 : 32'h1);
        check({tag, "_rdata"},   rdata, exp_rd);
        check({tag, "_err"},     {31'h0, err}, {31'h0, exp_err});
        check({tag, "_latency"}, cyc, exp_cyc);
        check({tag, "_idle_bus"}, {27'h0, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
                                   m_axi_arvalid, m_axi_rready}, 32'h0);
        if (!keep) req = 2'b00;
        slave_idle();
      end else begin
        // Wrong-direction channels stay quiet; valids stay stable, never repeat.
        if (is_wr && (m_axi_arvalid || m_axi_rready)) proto++;
        if (!is_wr && (m_axi_awvalid || m_axi_wvalid || m_axi_bready)) proto++;
        if (m_axi_awvalid && (aw_done || m_axi_awaddr !== ea)) proto++;
        if (m_axi_wvalid && (w_done || m_axi_wdata !== ed || m_axi_wstrb !== 4'hF)) proto++;
        if (m_axi_arvalid && (ar_done || m_axi_araddr !== ea)) proto++;

        m_axi_awready = m_axi_awvalid && (aw_wait >= aw_dly);
        if (m_axi_awvalid && !m_axi_awready) aw_wait++;
        m_axi_wready = m_axi_wvalid && (w_wait >= w_dly);
        if (m_axi_wvalid && !m_axi_wready) w_wait++;
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = resp;
        if (aw_done && w_done && !b_done) begin
          if (b_wait >= b_dly) m_axi_bvalid = 1'b1; else b_wait++;
        end
        m_axi_arready = m_axi_arvalid && (ar_wait >= ar_dly);
        if (m_axi_arvalid && !m_axi_arready) ar_wait++;
        m_axi_rvalid = 1'b0;
        m_axi_rresp  = resp;
        if (ar_done && !r_done) begin
          if (r_wait >= r_dly) m_axi_rvalid = 1'b1; else r_wait++;
        end
        m_axi_rdata = m_axi_rvalid ? sdata : 32'h0;

        // Handshakes that will complete on the coming rising edge.
        if (m_axi_awvalid && m_axi_awready) begin aw_done = 1; aw_beats++; end
        if (m_axi_wvalid && m_axi_wready)   begin w_done = 1;  w_beats++;  end
        if (m_axi_bvalid && m_axi_bready)   b_done = 1;
        if (m_axi_arvalid && m_axi_arready) begin ar_done = 1; ar_beats++; end
        if (m_axi_rvalid && m_axi_rready)   r_done = 1;
      end
    end
    if (!found) begin
      check({tag, "_done_seen"}, 32'h0, 32'h1);
      req = 2'b00;
      slave_idle();
    end
    check({tag, "_protocol"}, proto, 32'h0);
    check({tag, "_beats"}, {aw_beats[7:0], w_beats[7:0], ar_beats[7:0], 8'h0},
          (exp_tmo) ? 32'h0 :
          is_wr ? 32'h0101_0000 : 32'h0000_0100);
  endtask

  initial begin
    int gs;
    int order[4];
    logic [1:0] rr, ww, rs;

    reset = 1'b1; req = 2'b00; we = 2'b00; addr = '0; wdata = '0;
    slave_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    model_prio = 0;

    // Single write, zero-wait slave.
    run_txn("wr_basic", 2'b01, 2'b01, 32'h0000_0001, 32'h0, 32'h1234_5678, 32'h0,
            0, 0, 0, 0, 0, 2'b00, 32'h0, 0, 0, gs);
    check("wr_basic_gnt", gs, 0);

    // Read from requester 1 with a four-cycle rvalid delay.
    run_txn("rd_slow", 2'b10, 2'b00, 32'h0, 32'h0000_1003, 32'h0, 32'h0,
            0, 0, 0, 0, 4, 2'b00, 32'hCAFE_F00D, 0, 0, gs);
    check("rd_slow_gnt", gs, 1);

    // Both requesters held high across four back-to-back transactions.
    for (int i = 0; i < 4; i++) begin
      run_txn("rr_hold", 2'b11, i[1:0], 32'h100 + i, 32'h200 + i, $urandom, $urandom,
              0, 0, 0, 0, 0, 2'b00, $urandom, 1, 0, order[i]);
    end
    check("rr_order0", order[0], 0);
    check("rr_order1", order[1], 1);
    check("rr_order2", order[2], 0);
    check("rr_order3", order[3], 1);

    // AW accepted in cycle 1, W in cycle 3, SLVERR response.
    run_txn("wr_split", 2'b01, 2'b01, 32'h40, 32'h0, 32'hA5A5_5A5A, 32'h0,
            0, 2, 0, 0, 0, 2'b10, 32'h0, 0, 0, gs);

    // Randomized traffic.
    for (int i = 0; i < 20; i++) begin
      rr = 2'($urandom_range(1, 3));
      ww = 2'($urandom);
      rs = 2'($urandom);
      run_txn("rand", rr, ww, $urandom, $urandom, $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), rs, $urandom, 0, 0, gs);
    end

`ifdef ARB_TIMEOUT_EN
    // Read whose address is never accepted.
    run_txn("timeout", 2'b01, 2'b00, 32'h80, 32'h0, 32'h0, 32'h0,
            0, 0, 0, 1000, 0, 2'b00, 32'h0, 0, 1, gs);
`endif

    // Reset in the middle of a read: no done, everything back to zero, and
    // the tie-break pointer returns to requester 0.
    @(negedge clk);
    req = 2'b01; we = 2'b00; addr = {32'h0, 32'h0000_0C00};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midrst_inflight", {31'h0, m_axi_arvalid}, 32'h1);
    end
    reset = 1'b1;
    req = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all_zero("midrst");
    end
    reset = 1'b0;
    model_prio = 0;
    run_txn("post_rst", 2'b11, 2'b00, 32'h10, 32'h20, 32'h0, 32'h0,
            0, 0, 0, 1, 1, 2'b01, 32'h1357_9BDF, 0, 0, gs);
    check("post_rst_gnt", gs, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axil_reg_arbiter.md
AXIL_REG_ARBITER -- requirements
Module: axil_reg_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, watchdog limit in clk cycles (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have port req  in  2  per-requester level request; bit i = requester i.
REQ-005 SHALL have port we  in  2  per-requester write(1)/read(0) select; sampled with req.
REQ-006 SHALL have port addr  in  64  requester i address at bits [32i+31:32i].
REQ-007 SHALL have port wdata  in  64  requester i write data at bits [32i+31:32i].
REQ-008 SHALL have port done  out  2  one-cycle completion pulse to the served requester.
REQ-009 SHALL have port rdata  out  32  read data; valid while any done bit is high.
REQ-010 SHALL have port err  out  1  error flag; valid while any done bit is high.
REQ-011 SHALL have ports m_axi_awaddr out 32, m_axi_awvalid out 1, m_axi_awready in 1: AXI-Lite write-address channel.
REQ-012 SHALL have ports m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1: write-data channel.
REQ-013 SHALL have ports m_axi_bvalid in 1, m_axi_bready out 1, m_axi_bresp in 2: write-response channel.
REQ-014 SHALL have ports m_axi_araddr out 32, m_axi_arvalid out 1, m_axi_arready in 1: read-address channel.
REQ-015 SHALL have ports m_axi_rvalid in 1, m_axi_rready out 1, m_axi_rdata in 32, m_axi_rresp in 2: read-data channel.

Function
REQ-016 SHALL serve one transaction at a time; FSM states IDLE, WR, WRESP, RADDR, RDATA, DONE.
REQ-017 SHALL, in IDLE with any req bit high, grant one requester, latch its we/addr/wdata and go to WR (we=1) or RADDR (we=0) on the next edge.
REQ-018 SHALL arbitrate round-robin: single request wins; on simultaneous requests, the requester not granted last wins; after reset requester 0 has priority.
REQ-019 SHALL in WR assert awvalid and wvalid together, drop each independently on its own ready handshake, and enter WRESP once both have completed (same or different cycles).
REQ-020 SHALL drive m_axi_wstrb = 4'hF for every write.
REQ-021 SHALL in WRESP hold bready=1 and go to DONE on bvalid; err latched = (bresp != 0).
REQ-022 SHALL in RADDR hold arvalid until arready, then go to RDATA; in RDATA hold rready=1 and on rvalid capture rdata and err = (rresp != 0), then go to DONE.
REQ-023 SHALL in DONE pulse done[granted] for exactly one cycle with rdata/err valid, then return to IDLE; rdata for writes SHALL be 32'h0.
REQ-024 SHALL keep AXI address/data outputs stable while the corresponding valid is high.
REQ-025 SHALL ignore req changes after grant; a deasserted req mid-transaction still completes and pulses done.
REQ-026 SHALL require requesters to drop req the cycle after done; a req still high in IDLE is treated as a new request.
REQ-027 SHALL have minimum write latency grant-to-done of 3 cycles with zero-wait slave (IDLE, WR, WRESP, DONE).

Reset
REQ-028 SHALL on reset: state IDLE, round-robin pointer favours requester 0, all AXI valid/ready outputs 0, addr/data outputs 0, done 0, rdata 0, err 0, watchdog counter 0.
REQ-029 SHALL abort any in-flight transaction on reset without pulsing done.

Configuration
REQ-030 SHALL with ARB_TIMEOUT_EN defined count cycles spent outside IDLE/DONE; at count == TIMEOUT_CYCLES, deassert all AXI valid/ready, go to DONE with err=1 and rdata=32'h0BAD0BAD.
REQ-031 SHALL without ARB_TIMEOUT_EN contain no watchdog counter and wait indefinitely for handshakes.

Verification
REQ-032 Bench: req=01, we=1, addr0=0x0001, wdata0=0x12345678, zero-wait slave -> one AW/W beat, wstrb=F, done=01 at grant+3, err=0.
REQ-033 Bench: req=10, we=0, addr1=0x1003, slave rdata=0xCAFEF00D after 4-cycle rvalid delay -> done=10, rdata=0xCAFEF00D, err=0.
REQ-034 Bench: req=11 held continuously for 4 transactions -> grant order 0,1,0,1; no overlap of AXI transactions.
REQ-035 Bench: awready at cycle 1, wready at cycle 3, bresp=2'b10 -> awvalid drops after cycle 1, wvalid after cycle 3, done with err=1.
REQ-036 Bench (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): read with arready never asserted -> done after 16 cycles, err=1, rdata=0x0BAD0BAD; reset asserted mid-read -> no done, all outputs zero.
